wb_regfile: RTL and testbench

Writeback-stage register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs (`regwrite`, `memtoreg`, read data, ALU result, destination register) and selects the writeback value. It commits that value into a 32-entry general-purpose register array and serves the two ID-stage read ports. The selected writeback value is also exported for the EX-stage forwarding unit.

---
 rtl/wb_regfile.sv | 74 +++++++
 tb/tb_wb_regfile.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// MIPS writeback-stage register file: writeback mux, 32-entry GPR array, two async read ports.
// Optional macro WB_BYPASS_EN forwards the committing value to same-cycle reads (write-before-read).
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwrite,
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    always_comb begin
        wb_data  = memtoreg ? ReadData : ALUResult;
        wb_valid = regwrite && (WriteReg != '0) && !rst;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_valid) begin
            regs_d[WriteReg] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads are forced to zero during reset so stale contents never leak before the clearing edge.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        if (rst || addr == '0) begin
            val = '0;
        end else begin
            val = regs_q[addr];
`ifdef WB_BYPASS_EN
            if (wb_valid && WriteReg == addr) begin
                val = wb_data;
            end
`endif
        end
        return val;
    endfunction

    always_comb begin
        rs_data = read_port(rs_addr);
        rt_data = read_port(rt_addr);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized + directed bench for wb_regfile with a queue scoreboard and behavioural GPR model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] ReadData;
    logic [31:0] ALUResult;
    logic [4:0]  WriteReg;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        wb_valid;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .regwrite(regwrite), .memtoreg(memtoreg),
        .ReadData(ReadData), .ALUResult(ALUResult), .WriteReg(WriteReg),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_data(wb_data), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] wbd;
        logic        wbv;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [32];

    function automatic logic [31:0] exp_read(input logic [4:0] a, input logic r, input logic valid,
                                             input logic [4:0] wr, input logic [31:0] v);
        if (r || a == 5'd0) return 32'd0;
        if (BYP && valid && wr == a) return v;
        return model[a];
    endfunction

    task automatic check(input string name, input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s [%s]: got %h expected %h", name, tag, act, expv);
        end
    endtask

    // Monitor: combinational outputs are presented every cycle; sample mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("rs_data", e.tag, rs_data, e.rs);
            check("rt_data", e.tag, rt_data, e.rt);
            check("wb_data", e.tag, wb_data, e.wbd);
            check("wb_valid", e.tag, {31'd0, wb_valid}, {31'd0, e.wbv});
            $display("txn %-8s rs=%h rt=%h wb=%h v=%b", e.tag, rs_data, rt_data, wb_data, wb_valid);
        end
    end

    task automatic drive(input logic r, input logic rw, input logic mtr, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] wr, input logic [4:0] ra,
                         input logic [4:0] rb, input string tag);
        exp_t        e;
        logic [31:0] v;
        logic        valid;
        rst = r; regwrite = rw; memtoreg = mtr; ReadData = rd; ALUResult = alu;
        WriteReg = wr; rs_addr = ra; rt_addr = rb;
        v     = mtr ? rd : alu;
        valid = rw && (wr != 5'd0) && !r;
        e.wbd = v;
        e.wbv = valid;
        e.rs  = exp_read(ra, r, valid, wr, v);
        e.rt  = exp_read(rb, r, valid, wr, v);
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (valid) begin
            model[wr] = v;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rst = 1'b1; regwrite = 1'b0; memtoreg = 1'b0; ReadData = '0; ALUResult = '0;
        WriteReg = '0; rs_addr = '0; rt_addr = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) begin
            drive(i < 4, 1'b0, 1'b0, $urandom, $urandom, 5'(i), 5'(i), 5'(31 - i), "sweep");
        end

        drive(0, 1, 0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd0, "wr5");
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6, "rd5");
        drive(0, 1, 1, 32'h12345678, 32'h0BAD0BAD, 5'd6, 5'd5, 5'd6, "wr6");
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6, "rd6");
        drive(0, 1, 0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, "wr0");
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, "rd0");
        drive(0, 1, 0, 32'h0, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7, "wr7");
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7, "rd7");
        drive(0, 1, 0, 32'h0, 32'h55, 5'd3, 5'd3, 5'd3, "wr3");
        drive(1, 1, 0, 32'h0, 32'h11, 5'd3, 5'd3, 5'd3, "rstwr3");
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd5, "rd3");
        drive(0, 1, 0, 32'h0, 32'h1, 5'd9, 5'd9, 5'd9, "wr9a");
        drive(0, 0, 0, 32'h0, 32'h2, 5'd9, 5'd9, 5'd9, "gap9");
        drive(0, 1, 0, 32'h0, 32'h3, 5'd9, 5'd9, 5'd9, "wr9c");
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9, "rd9");
        drive(0, 1, 0, 32'h0, 32'h4, 5'd9, 5'd9, 5'd1, "b2b9a");
        drive(0, 1, 1, 32'h5, 32'h0, 5'd9, 5'd9, 5'd9, "b2b9b");

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr, ra, rb;
            wr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ra = ($urandom_range(0, 1) == 0) ? wr : 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom, $urandom, wr, ra, rb, "rand");
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
